tinyalu_stim_gen: RTL and testbench

TINYALU_STIM_GEN -- requirements
Module: tinyalu_stim_gen

---
 rtl/tinyalu_stim_pkg.sv | 32 +++
 rtl/tinyalu_lfsr32.sv | 26 ++
 rtl/tinyalu_stim_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_tinyalu_stim_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_stim_pkg.sv
// Shared types for the TinyALU stimulus generator: opcodes, FSM states and
// the LFSR feedback taps plus the single-step helper used by both RTL files.
package tinyalu_stim_pkg;

  typedef enum logic [2:0] {
    OP_NO_OP = 3'd0,
    OP_ADD   = 3'd1,
    OP_AND   = 3'd2,
    OP_XOR   = 3'd3,
    OP_MUL   = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } state_e;

  // Taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_advance(input logic [31:0] cur);
    return {cur[30:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [31:0] lfsr_fix_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? 32'd1 : seed;
  endfunction

endpackage

// File: rtl/tinyalu_lfsr32.sv
// 32-bit Fibonacci LFSR, shift left with feedback into bit 0.
// A zero seed is replaced by 1 so the register never locks up.
module tinyalu_lfsr32
  import tinyalu_stim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      q_q <= lfsr_fix_seed(seed);
    end else if (step) begin
      q_q <= lfsr_advance(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tinyalu_stim_gen.sv
// TinyALU stimulus generator: issues a directed prefix (when built with
// TINYALU_STIM_DIRECTED_EN) followed by NUM_RANDOM LFSR-driven operations.
module tinyalu_stim_gen
  import tinyalu_stim_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          NUM_RANDOM = 10,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001,
  parameter int          TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output logic [2:0]          op,
  output logic                start,
  input  logic                done,
  input  logic [2*DATA_W-1:0] result,
  output logic                res_valid,
  output logic [2*DATA_W-1:0] res_data,
  output logic [DATA_W-1:0]   res_a,
  output logic [DATA_W-1:0]   res_b,
  output logic [2:0]          res_op,
  output logic                busy,
  output logic                finished,
  output logic                timeout_err,
  output logic [15:0]         op_count,
  output logic [2:0]          dbg_state
);

`ifdef TINYALU_STIM_DIRECTED_EN
  localparam int NUM_DIR = 4;
`else
  localparam int NUM_DIR = 0;
`endif
  localparam logic [16:0] TOTAL_OPS = 17'(NUM_DIR + NUM_RANDOM);

  // The wait budget includes the ISSUE cycle, so start is high for exactly
  // TIMEOUT cycles before a timeout drops it.
  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

  localparam logic [15:0]       ALT16 = 16'h5555;
  localparam logic [DATA_W-1:0] ONES  = '1;
  localparam logic [DATA_W-1:0] ALT   = ALT16[DATA_W-1:0];

  state_e                state_q, state_d;
  logic [16:0]           idx_q, idx_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic                  res_valid_q, res_valid_d;
  logic [2*DATA_W-1:0]   res_data_q, res_data_d;
  logic [DATA_W-1:0]     res_a_q, res_a_d, res_b_q, res_b_d;
  logic [2:0]            res_op_q, res_op_d;
  logic [15:0]           op_count_q, op_count_d;
  logic                  timeout_q, timeout_d;

  logic [31:0]           lfsr_q, lfsr_nxt;
  logic                  lfsr_step;
  logic                  enter_issue;
  logic [DATA_W-1:0]     nxt_a, nxt_b;
  logic [2:0]            nxt_op;
  logic                  nxt_random;

  tinyalu_lfsr32 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .seed  (LFSR_SEED),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  // Operands are taken from the post-step LFSR value so they are valid in the
  // first ISSUE cycle, the same edge on which the LFSR itself advances.
  assign lfsr_nxt = lfsr_advance(lfsr_q);

  always_comb begin
    nxt_a      = DATA_W'(lfsr_nxt);
    nxt_b      = DATA_W'(lfsr_nxt >> DATA_W);
    nxt_op     = {1'b0, lfsr_nxt[31:30]} + 3'd1;
    nxt_random = 1'b1;
`ifdef TINYALU_STIM_DIRECTED_EN
    if (idx_q < 17'(NUM_DIR)) begin
      nxt_random = 1'b0;
      case (idx_q[1:0])
        2'd0: begin
          nxt_a  = ONES;
          nxt_b  = DATA_W'(1);
          nxt_op = OP_ADD;
        end
        2'd1: begin
          nxt_a  = ONES - DATA_W'(1);
          nxt_b  = DATA_W'(3);
          nxt_op = OP_MUL;
        end
        2'd2: begin
          nxt_a  = ALT;
          nxt_b  = ONES;
          nxt_op = OP_AND;
        end
        default: begin
          nxt_a  = ALT;
          nxt_b  = ONES;
          nxt_op = OP_XOR;
        end
      endcase
    end
`endif
  end

  // Handshake: start is high through ISSUE and every WAIT cycle up to and
  // including the one where done is sampled; done outside WAIT is ignored.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    res_op_d    = res_op_q;
    op_count_d  = op_count_q;
    timeout_d   = timeout_q;
    lfsr_step   = 1'b0;
    enter_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          if (TOTAL_OPS == 17'd0) begin
            state_d = FINISH;
          end else begin
            state_d     = ISSUE;
            enter_issue = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (done) begin
          state_d     = GAP;
          res_valid_d = 1'b1;
          res_data_d  = result;
          res_a_d     = a_q;
          res_b_d     = b_q;
          res_op_d    = op_q;
          op_count_d  = op_count_q + 16'd1;
        end else if (wait_cnt_q == TO_LAST) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (idx_q < TOTAL_OPS) begin
          state_d     = ISSUE;
          enter_issue = 1'b1;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (go) begin
          state_d    = IDLE;
          op_count_d = '0;
          timeout_d  = 1'b0;
          idx_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_issue) begin
      a_d       = nxt_a;
      b_d       = nxt_b;
      op_d      = nxt_op;
      idx_d     = idx_q + 17'd1;
      lfsr_step = nxt_random;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_op_q    <= '0;
      op_count_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_op_q    <= res_op_d;
      op_count_q  <= op_count_d;
      timeout_q   <= timeout_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign op          = op_q;
  assign start       = (state_q == ISSUE) || (state_q == WAIT);
  assign busy        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == GAP);
  assign finished    = (state_q == FINISH);
  assign timeout_err = timeout_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_a       = res_a_q;
  assign res_b       = res_b_q;
  assign res_op      = res_op_q;
  assign op_count    = op_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tinyalu_stim_gen.sv
// Bench for tinyalu_stim_gen: stub ALU, expected-result queue, directed runs
// covering reset, back-to-back runs, timeout, mid-operation reset and zero ops.
module tb_tinyalu_stim_gen;
  import tinyalu_stim_pkg::*;

`ifdef TINYALU_STIM_DIRECTED_EN
  localparam int NDIR = 4;
`else
  localparam int NDIR = 0;
`endif
  localparam int          NRAND = 10;
  localparam int          TOTAL = NDIR + NRAND;
  localparam int          W     = 35;
  localparam logic [31:0] SEED  = 32'hACE1_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        go;
  logic [7:0]  A, B, res_a, res_b;
  logic [2:0]  op, res_op, dbg_state;
  logic        start, res_valid, busy, finished, timeout_err;
  logic        done = 1'b0;
  logic [15:0] result = '0;
  logic [15:0] res_data, op_count;

  tinyalu_stim_gen #(.DATA_W(8), .NUM_RANDOM(NRAND), .LFSR_SEED(SEED), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .go(go), .A(A), .B(B), .op(op), .start(start),
    .done(done), .result(result), .res_valid(res_valid), .res_data(res_data),
    .res_a(res_a), .res_b(res_b), .res_op(res_op), .busy(busy), .finished(finished),
    .timeout_err(timeout_err), .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- zero-random DUT, done tied to start ----------------
  logic        z_go;
  logic [7:0]  z_a, z_b, z_res_a, z_res_b;
  logic [2:0]  z_op, z_res_op, z_dbg_state;
  logic        z_start, z_res_valid, z_busy, z_finished, z_timeout_err;
  logic [15:0] z_res_data, z_op_count;
  int          z_start_cnt = 0;

  tinyalu_stim_gen #(.DATA_W(8), .NUM_RANDOM(0), .LFSR_SEED(SEED), .TIMEOUT(64)) dut_zero (
    .clk(clk), .reset(reset), .go(z_go), .A(z_a), .B(z_b), .op(z_op), .start(z_start),
    .done(z_start), .result(16'h1234), .res_valid(z_res_valid), .res_data(z_res_data),
    .res_a(z_res_a), .res_b(z_res_b), .res_op(z_res_op), .busy(z_busy),
    .finished(z_finished), .timeout_err(z_timeout_err), .op_count(z_op_count),
    .dbg_state(z_dbg_state)
  );

  always @(negedge clk) if (!reset && z_start) z_start_cnt++;

  // ---------------- reference ALU + stub ----------------
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] o);
    case (o)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  logic stub_silent = 1'b0;
  int   stub_cnt = 0;
  always @(posedge clk) begin
    if (start && !stub_silent) begin
      if (stub_cnt == 2) begin
        done     <= 1'b1;
        result   <= alu_ref(A, B, op);
        stub_cnt <= 0;
      end else begin
        done     <= 1'b0;
        stub_cnt <= stub_cnt + 1;
      end
    end else begin
      done     <= 1'b0;
      stub_cnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [W-1:0]  exp_q[$];
  logic [18:0]   obs_q[$];
  logic [18:0]   run1_obs[$];
  logic [31:0]   m_lfsr;
  logic [7:0]    dir_a [4] = '{8'hFF, 8'hFE, 8'h55, 8'h55};
  logic [7:0]    dir_b [4] = '{8'h01, 8'h03, 8'hFF, 8'hFF};
  logic [2:0]    dir_op[4] = '{3'd1, 3'd4, 3'd2, 3'd3};

  // Model the operation list of one run; push=0 only advances the model LFSR.
  task automatic push_run(input int n, input bit push);
    logic [7:0] a, b;
    logic [2:0] o;
    for (int i = 0; i < n; i++) begin
      if (i < NDIR) begin
        a = dir_a[i];
        b = dir_b[i];
        o = dir_op[i];
      end else begin
        m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
        a = m_lfsr[7:0];
        b = m_lfsr[15:8];
        o = {1'b0, m_lfsr[31:30]} + 3'd1;
      end
      if (push) exp_q.push_back({o, a, b, alu_ref(a, b, o)});
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] exp_v;
  int           rv_count = 0;
  logic         done_pend = 1'b0;
  logic         prev_busy = 1'b0;
  logic [15:0]  prev_cnt = '0;

  always @(negedge clk) begin
    if (done_pend && !reset) begin
      check("start_low_after_done", {31'd0, start}, 32'd0);
      check("res_valid_after_done", {31'd0, res_valid}, 32'd1);
    end
    done_pend = !reset && done && start;
    if (!reset && res_valid) begin
      rv_count++;
      obs_q.push_back({res_op, res_a, res_b});
      check("res_op_range", {31'd0, (res_op >= 3'd1 && res_op <= 3'd4)}, 32'd1);
      check("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check("res_op",   {29'd0, res_op},  {29'd0, exp_v[34:32]});
        check("res_a",    {24'd0, res_a},   {24'd0, exp_v[31:24]});
        check("res_b",    {24'd0, res_b},   {24'd0, exp_v[23:16]});
        check("res_data", {16'd0, res_data}, {16'd0, exp_v[15:0]});
      end
    end
    if (!reset && busy && prev_busy)
      check("op_count_monotonic",
            {31'd0, (op_count == prev_cnt) || (op_count == prev_cnt + 16'd1)}, 32'd1);
    prev_busy = !reset && busy;
    prev_cnt  = op_count;
  end

  // ---------------- driver tasks ----------------
  task automatic go_pulse();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic z_go_pulse();
    @(negedge clk) z_go = 1'b1;
    @(negedge clk) z_go = 1'b0;
  endtask

  task automatic wait_finished(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (finished) break;
      @(negedge clk);
    end
    check("finish_within_budget", {31'd0, finished}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int   start_cnt;
  int   rises;
  logic prev_start;
  bit   diff;

  initial begin
    reset = 1'b1;
    go = 1'b0;
    z_go = 1'b0;
    m_lfsr = SEED;
    repeat (3) @(negedge clk);
    check("rst_start",     {31'd0, start}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_finished",  {31'd0, finished}, 32'd0);
    check("rst_timeout",   {31'd0, timeout_err}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_operands",  {13'd0, op, A, B}, 32'd0);
    check("rst_results",   {res_data, res_a, res_b}, 32'd0);
    check("rst_op_count",  {16'd0, op_count}, 32'd0);
    check("rst_state",     {29'd0, dbg_state}, 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Run 1: single go pulse.
    push_run(TOTAL, 1'b1);
    go_pulse();
    wait_finished(2000);
    check("run1_op_count", {16'd0, op_count}, TOTAL);
    check("run1_timeout",  {31'd0, timeout_err}, 32'd0);
    check("run1_sb_empty", exp_q.size(), 32'd0);
    check("run1_obs_size", obs_q.size(), TOTAL);
    // From seed ACE10001 the first step gives 59C20003: A=03 B=00 op=2.
    check("run1_first_random", {13'd0, obs_q[NDIR]}, {13'd0, 3'd2, 8'h03, 8'h00});
    run1_obs = obs_q;
    obs_q.delete();
    go_pulse();
    check("idle_state",    {29'd0, dbg_state}, 32'(IDLE));
    check("idle_op_count", {16'd0, op_count}, 32'd0);
    check("idle_finished", {31'd0, finished}, 32'd0);

    // Run 2: go held high well into the busy phase.
    push_run(TOTAL, 1'b1);
    @(negedge clk) go = 1'b1;
    repeat (20) @(negedge clk);
    go = 1'b0;
    wait_finished(2000);
    check("run2_op_count", {16'd0, op_count}, TOTAL);
    check("run2_sb_empty", exp_q.size(), 32'd0);
    check("run2_obs_size", obs_q.size(), TOTAL);
    diff = 1'b0;
    for (int k = NDIR; k < TOTAL; k++)
      if (obs_q.size() == TOTAL && obs_q[k] !== run1_obs[k]) diff = 1'b1;
    check("run2_stream_differs", {31'd0, diff}, 32'd1);
    obs_q.delete();
    go_pulse();

    // Timeout: stub never answers.
    stub_silent = 1'b1;
    push_run(1, 1'b0);
    go_pulse();
    start_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (start) start_cnt++;
      if (finished) break;
      @(negedge clk);
    end
    check("timeout_start_cycles", start_cnt, 32'd64);
    check("timeout_err_set",      {31'd0, timeout_err}, 32'd1);
    check("timeout_finished",     {31'd0, finished}, 32'd1);
    check("timeout_op_count",     {16'd0, op_count}, 32'd0);
    repeat (5) @(negedge clk);
    check("timeout_err_held",     {31'd0, timeout_err}, 32'd1);
    check("timeout_start_low",    {31'd0, start}, 32'd0);
    go_pulse();
    check("timeout_err_cleared",  {31'd0, timeout_err}, 32'd0);
    stub_silent = 1'b0;

    // Reset during the second WAIT.
    push_run(TOTAL, 1'b1);
    rv_count = 0;
    go_pulse();
    rises = 1;
    prev_start = start;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(negedge clk);
      if (start && !prev_start) rises++;
      prev_start = start;
    end
    check("second_issue_seen", rises, 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_start", {31'd0, start}, 32'd0);
    check("rst_mid_state", {29'd0, dbg_state}, 32'(IDLE));
    check("rst_mid_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_rv_count", rv_count, 32'd1);
    check("rst_mid_op_count", {16'd0, op_count}, 32'd0);
    exp_q.delete();
    obs_q.delete();
    m_lfsr = SEED;

    // After reset the LFSR restarts from the seed.
    push_run(TOTAL, 1'b1);
    go_pulse();
    wait_finished(2000);
    check("reseed_op_count", {16'd0, op_count}, TOTAL);
    check("reseed_obs_size", obs_q.size(), TOTAL);
    check("reseed_first_random", {13'd0, obs_q[NDIR]}, {13'd0, 3'd2, 8'h03, 8'h00});

    // Zero random operations on the second instance.
    z_go_pulse();
`ifdef TINYALU_STIM_DIRECTED_EN
    for (int i = 0; i < 200; i++) begin
      if (z_finished) break;
      @(negedge clk);
    end
    check("zero_finished",   {31'd0, z_finished}, 32'd1);
    check("zero_op_count",   {16'd0, z_op_count}, 32'd4);
    check("zero_start_cnt",  z_start_cnt, 32'd8);
`else
    check("zero_finished_next", {31'd0, z_finished}, 32'd1);
    check("zero_busy",          {31'd0, z_busy}, 32'd0);
    check("zero_start_never",   z_start_cnt, 32'd0);
    check("zero_op_count",      {16'd0, z_op_count}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
